// File: rtl/ber_monitor_if.sv
// Sample and result bundle for ber_monitor: the master drives control and sample words,
// the slave (the monitor) returns status and the last completed window's results.
interface ber_monitor_if;
    logic        start;
    logic        abort;
    logic        valid;
    logic [63:0] golden;
    logic [63:0] observed;
    logic        busy;
    logic        done;
    logic [31:0] err_bits;
    logic [31:0] err_words;
    logic [63:0] ber_est;

    modport master (
        output start, abort, valid, golden, observed,
        input  busy, done, err_bits, err_words, ber_est
    );

    modport slave (
        input  start, abort, valid, golden, observed,
        output busy, done, err_bits, err_words, ber_est
    );
endinterface

// File: rtl/ber_monitor.sv
// Windowed bit-error-rate monitor: compares golden vs observed words over 2^WindowLog2 samples
// and reports error bits, error words and a probability*2^64 BER estimate.
module ber_popcnt_lane #(
    parameter int VEC_W = 8,
    parameter int CW    = $clog2(VEC_W + 1)
) (
    input  logic [VEC_W-1:0] vec_i,
    output logic [CW-1:0]    cnt_o
);
    always_comb begin
        cnt_o = '0;
        for (int b = 0; b < VEC_W; b++) cnt_o = cnt_o + CW'(vec_i[b]);
    end
endmodule

module ber_monitor #(
    parameter int DataWidth  = 64,
    parameter int WindowLog2 = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    ber_monitor_if.slave  bus
);
    localparam int VEC_W     = 8;
    localparam int NUM_LANES = DataWidth / VEC_W;
    localparam int LANE_CW   = $clog2(VEC_W + 1);
    localparam int STAGES    = 2;
    localparam int SHIFT     = 58 - WindowLog2;
    localparam logic [WindowLog2-1:0] LAST = WindowLog2'((1 << WindowLog2) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                              state_q, state_d;
    logic                                drain_q, drain_d;
    logic                                accept, clr, load, kill, busy;
    logic [WindowLog2-1:0]               cnt_q;
    logic [STAGES:1]                     vld_pipe_q;
    logic [NUM_LANES-1:0][VEC_W-1:0]     diff_q;
    logic [NUM_LANES-1:0][LANE_CW-1:0]   lane_cnt;
    logic [6:0]                          pop_d, pop_q;
    logic [31:0]                         acc_bits_q, acc_words_q;
    logic [31:0]                         err_bits_q, err_words_q;
    logic [63:0]                         ber_q;
    logic                                done_q;
    logic [64:0]                         ber_wide;

    // Abort outranks every other event once a window is in flight.
    assign kill = bus.abort && (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        drain_d = 1'b0;
        accept  = 1'b0;
        clr     = 1'b0;
        load    = 1'b0;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    clr     = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.valid) begin
                    accept = 1'b1;
                    if (cnt_q == LAST) state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (bus.abort)    state_d = IDLE;
                else if (drain_q) state_d = DONE;
                else              drain_d = 1'b1;
            end
            DONE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    load    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Popcount split into byte lanes, summed into the stage-2 register.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        ber_popcnt_lane #(.VEC_W(VEC_W), .CW(LANE_CW)) u_lane (
            .vec_i (diff_q[l]),
            .cnt_o (lane_cnt[l])
        );
    end

    always_comb begin
        pop_d = '0;
        for (int l = 0; l < NUM_LANES; l++) pop_d = pop_d + 7'(lane_cnt[l]);
    end

    assign ber_wide = 65'(acc_bits_q) << SHIFT;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            vld_pipe_q  <= '0;
            diff_q      <= '0;
            pop_q       <= '0;
            acc_bits_q  <= '0;
            acc_words_q <= '0;
            err_bits_q  <= '0;
            err_words_q <= '0;
            ber_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1] & {(STAGES-1){!kill}}, accept};
            if (accept) diff_q <= bus.golden ^ bus.observed;
            pop_q <= pop_d;
            if (clr)         cnt_q <= '0;
            else if (accept) cnt_q <= cnt_q + 1'b1;
            if (clr) begin
                acc_bits_q  <= '0;
                acc_words_q <= '0;
            end else if (vld_pipe_q[STAGES] && !kill) begin
                acc_bits_q  <= acc_bits_q + 32'(pop_q);
                acc_words_q <= acc_words_q + 32'(pop_q != 7'd0);
            end
            if (load) begin
                err_bits_q  <= acc_bits_q;
                err_words_q <= acc_words_q;
                ber_q       <= ber_wide[64] ? '1 : ber_wide[63:0];
            end
            done_q <= load;
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done_q;
    assign bus.err_bits  = err_bits_q;
    assign bus.err_words = err_words_q;
    assign bus.ber_est   = ber_q;
endmodule
